// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch state encoding, PC step and queue entry type
package fetch_unit_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, FLUSH} fetch_state_t;
    localparam logic [31:0] PC_INC = 32'd4;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction memory, redirect and decode handshake bundle
interface fetch_unit_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    modport master (
        output imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o,
        input  imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, inst_ready_i
    );
    modport slave (
        input  imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o,
        output imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, inst_ready_i
    );
endinterface

// File: rtl/fetch_unit_inst_queue.sv
// inst_queue: synchronous instruction FIFO with push, pop, flush and occupancy count
module inst_queue
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  fetch_entry_t             data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output fetch_entry_t             data_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    fetch_entry_t mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [AW:0]   count_q;
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + AW'(1);
            if (pop_i) rd_q <= rd_q + AW'(1);
            count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q] <= data_i;
    end
    assign data_o  = mem_q[rd_q];
    assign count_o = count_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher feeding a small decode queue
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    fetch_unit_if.master  bus
);
    localparam int CW = $clog2(QDEPTH) + 1;
    fetch_state_t state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
    logic [CW-1:0] count;
    logic         req, push, pop;
    fetch_entry_t wr_entry, head;
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        req        = 1'b0;
        push       = 1'b0;
        case (state_q)
            IDLE: begin
                req = !bus.redirect_i && count < CW'(QDEPTH);
                if (req) begin
                    state_d    = WAIT;
                    fetch_pc_d = fetch_pc_q + PC_INC;
                    req_pc_d   = fetch_pc_q;
                end
            end
            WAIT: begin
                // a response coinciding with a redirect is stale and dropped
                if (bus.redirect_i) state_d = bus.imem_rvalid_i ? IDLE : FLUSH;
                else if (bus.imem_rvalid_i) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            FLUSH:   state_d = bus.imem_rvalid_i ? IDLE : FLUSH;
            default: state_d = IDLE;
        endcase
        if (bus.redirect_i) fetch_pc_d = bus.redirect_pc_i & ~32'h3;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end
    assign pop      = bus.inst_valid_o && bus.inst_ready_i && !bus.redirect_i;
    assign wr_entry = '{pc: req_pc_q, inst: bus.imem_rdata_i};
    inst_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (wr_entry),
        .pop_i   (pop),
        .flush_i (bus.redirect_i),
        .data_o  (head),
        .count_o (count)
    );
    assign bus.imem_req_o   = req && rst_ni;
    assign bus.imem_addr_o  = fetch_pc_q;
    assign bus.inst_valid_o = count != '0;
    assign bus.inst_o       = head.inst;
    assign bus.inst_pc_o    = head.pc;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a latency-configurable memory
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst_ni;
    int checks = 0;
    int errors = 0;
    int lat = 1;
    logic        pend = 1'b0;
    int          pcnt = 0;
    logic [31:0] paddr = '0;
    logic [31:0] req_log [$];
    logic [63:0] pop_log [$];
    fetch_unit_if bus ();
    fetch_unit dut (.clk_i(clk), .rst_ni(rst_ni), .bus(bus.master));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask
    // one clock: observe handshakes, then advance the memory model
    task automatic cycle();
        logic        saw;
        logic [31:0] saddr;
        #1;
        saw   = bus.imem_req_o && rst_ni;
        saddr = bus.imem_addr_o;
        if (saw) req_log.push_back(saddr);
        if (bus.inst_valid_o && bus.inst_ready_i && rst_ni) pop_log.push_back({bus.inst_pc_o, bus.inst_o});
        @(posedge clk);
        @(negedge clk);
        bus.imem_rvalid_i = 1'b0;
        if (saw) begin
            pend  = 1'b1;
            pcnt  = lat;
            paddr = saddr;
        end
        if (pend) begin
            pcnt--;
            if (pcnt == 0) begin
                bus.imem_rvalid_i = 1'b1;
                bus.imem_rdata_i  = {paddr[15:0], 16'hC0DE};
                pend = 1'b0;
            end
        end
    endtask
    task automatic do_reset();
        rst_ni = 1'b0;
        cycle();
        cycle();
        rst_ni = 1'b1;
        req_log.delete();
        pop_log.delete();
    endtask
    initial begin
        rst_ni = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = '0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        bus.inst_ready_i  = 1'b1;
        @(negedge clk);
        cycle();
        cycle();
        #1;
        check("rst_req", 32'(bus.imem_req_o), 32'd0);
        check("rst_valid", 32'(bus.inst_valid_o), 32'd0);
        rst_ni = 1'b1;
        #1;
        check("first_req", 32'(bus.imem_req_o), 32'd1);
        check("first_addr", bus.imem_addr_o, 32'h0);
        req_log.delete();
        pop_log.delete();
        repeat (7) cycle();
        check("s1_req0", req_log[0], 32'h0);
        check("s1_req1", req_log[1], 32'h4);
        check("s1_req2", req_log[2], 32'h8);
        check("s1_pop0", pop_log[0][63:32], 32'h0);
        check("s1_inst0", pop_log[0][31:0], 32'h0000_C0DE);
        check("s1_pop1", pop_log[1][63:32], 32'h4);
        check("s1_inst1", pop_log[1][31:0], 32'h0004_C0DE);
        check("s1_pop2", pop_log[2][63:32], 32'h8);
        check("s1_inst2", pop_log[2][31:0], 32'h0008_C0DE);
        bus.inst_ready_i = 1'b0;
        req_log.delete();
        pop_log.delete();
        cycle();
        #1;
        check("stall_head_early", bus.inst_pc_o, 32'hC);
        repeat (19) cycle();
        #1;
        check("stall_req", 32'(bus.imem_req_o), 32'd0);
        check("stall_valid", 32'(bus.inst_valid_o), 32'd1);
        check("stall_head_pc", bus.inst_pc_o, 32'hC);
        check("stall_head_inst", bus.inst_o, 32'h000C_C0DE);
        check("stall_nreq", 32'(req_log.size()), 32'd3);
        bus.inst_ready_i = 1'b1;
        pop_log.delete();
        repeat (4) cycle();
        check("drain_n", 32'(pop_log.size()), 32'd4);
        check("drain0", pop_log[0][63:32], 32'hC);
        check("drain1", pop_log[1][63:32], 32'h10);
        check("drain2", pop_log[2][63:32], 32'h14);
        check("drain3", pop_log[3][63:32], 32'h18);
        check("drain3_inst", pop_log[3][31:0], 32'h0018_C0DE);
        lat = 3;
        do_reset();
        cycle();
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h103;
        #1;
        check("redir_wait_req", 32'(bus.imem_req_o), 32'd0);
        cycle();
        bus.redirect_i = 1'b0;
        #1;
        check("flush_req", 32'(bus.imem_req_o), 32'd0);
        check("flush_valid", 32'(bus.inst_valid_o), 32'd0);
        cycle();
        #1;
        check("flush_stale_req", 32'(bus.imem_req_o), 32'd0);
        cycle();
        #1;
        check("flush_drop_valid", 32'(bus.inst_valid_o), 32'd0);
        check("flush_next_req", 32'(bus.imem_req_o), 32'd1);
        check("flush_next_addr", bus.imem_addr_o, 32'h100);
        lat = 1;
        cycle();
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h240;
        cycle();
        bus.redirect_i = 1'b0;
        #1;
        check("coinc_valid", 32'(bus.inst_valid_o), 32'd0);
        check("coinc_req", 32'(bus.imem_req_o), 32'd1);
        check("coinc_addr", bus.imem_addr_o, 32'h240);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'hFFFF_FFFE;
        #1;
        check("redir_idle_req", 32'(bus.imem_req_o), 32'd0);
        cycle();
        bus.redirect_i = 1'b0;
        req_log.delete();
        cycle();
        cycle();
        #1;
        check("wrap_valid", 32'(bus.inst_valid_o), 32'd1);
        check("wrap_pc", bus.inst_pc_o, 32'hFFFF_FFFC);
        check("wrap_inst", bus.inst_o, 32'hFFFC_C0DE);
        cycle();
        check("wrap_req0", req_log[0], 32'hFFFF_FFFC);
        check("wrap_req1", req_log[1], 32'h0);
        cycle();
        #1;
        check("prio_head", bus.inst_pc_o, 32'h0);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h40;
        cycle();
        bus.redirect_i = 1'b0;
        #1;
        check("prio_valid", 32'(bus.inst_valid_o), 32'd0);
        check("prio_addr", bus.imem_addr_o, 32'h40);
        lat = 3;
        do_reset();
        cycle();
        rst_ni = 1'b0;
        cycle();
        cycle();
        rst_ni = 1'b1;
        #1;
        check("late_req", 32'(bus.imem_req_o), 32'd1);
        check("late_addr", bus.imem_addr_o, 32'h0);
        cycle();
        #1;
        check("late_ignored", 32'(bus.inst_valid_o), 32'd0);
        repeat (3) cycle();
        #1;
        check("late_fresh_valid", 32'(bus.inst_valid_o), 32'd1);
        check("late_fresh_pc", bus.inst_pc_o, 32'h0);
        check("late_fresh_inst", bus.inst_o, 32'h0000_C0DE);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter QDEPTH, default 4, meaning instruction queue entries (power of two, 2..16).
REQ-003 SHALL have one clock; reset is synchronous and active-low: clk_i  in  1  clock, rising edge; rst_ni  in  1  synchronous active-low reset.
REQ-004 SHALL have imem_req_o  out  1  instruction memory read request, one outstanding maximum.
REQ-005 SHALL have imem_addr_o  out  32  word-aligned fetch address, valid while imem_req_o=1.
REQ-006 SHALL have imem_rvalid_i  in  1  read data valid, arrives 1..N cycles after the request.
REQ-007 SHALL have imem_rdata_i  in  32  instruction word, valid while imem_rvalid_i=1.
REQ-008 SHALL have redirect_i  in  1  taken branch/jump; flush and restart fetch.
REQ-009 SHALL have redirect_pc_i  in  32  new fetch address, valid while redirect_i=1.
REQ-010 SHALL have inst_valid_o  out  1  queue head holds a valid instruction.
REQ-011 SHALL have inst_ready_i  in  1  decode accepts the head this cycle.
REQ-012 SHALL have inst_o  out  32  instruction at queue head.
REQ-013 SHALL have inst_pc_o  out  32  PC of inst_o.

Function
REQ-014 SHALL implement FSM states IDLE (no request outstanding), WAIT (request outstanding), and FLUSH (outstanding response to be discarded).
REQ-015 SHALL, in IDLE, assert imem_req_o for exactly one cycle at fetch_pc when queue occupancy < QDEPTH, then go to WAIT and set fetch_pc = fetch_pc + 4.
REQ-016 SHALL compute fetch_pc + 4 modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-017 SHALL, in WAIT on imem_rvalid_i=1, push {fetch address, imem_rdata_i} into the queue and return to IDLE; a new request may issue on the next cycle (one-cycle bubble minimum).
REQ-018 SHALL make a pushed entry visible on inst_valid_o/inst_o/inst_pc_o on the cycle after imem_rvalid_i.
REQ-019 SHALL pop the head when inst_valid_o=1 and inst_ready_i=1; hold the outputs stable while inst_valid_o=1 and inst_ready_i=0.
REQ-020 SHALL allow push and pop in the same cycle, leaving occupancy unchanged.
REQ-021 SHALL drive inst_valid_o=0 when the queue is empty; inst_o and inst_pc_o are don't-care then.
REQ-022 SHALL never issue a request that would overflow the queue; reserve one slot while in WAIT.
REQ-023 SHALL, on redirect_i=1:
  - empty the queue in the same cycle, so inst_valid_o=0 on the next cycle;
  - set fetch_pc = {redirect_pc_i[31:2], 2'b00};
  - go to FLUSH if in WAIT, otherwise go to IDLE.
REQ-024 SHALL, in FLUSH, discard the next imem_rvalid_i and go to IDLE.
REQ-025 SHALL, when redirect_i and imem_rvalid_i coincide in WAIT, discard the data and go directly to IDLE.
REQ-026 SHALL give redirect_i priority over a same-cycle pop; a pop in that cycle is ignored.
REQ-027 SHALL not assert imem_req_o in the same cycle as redirect_i.
REQ-028 SHALL ignore imem_rvalid_i in IDLE.

Reset
REQ-029 SHALL, while rst_ni=0 at a rising clk_i edge:
  - set FSM=IDLE and fetch_pc=RESET_PC;
  - empty the queue;
  - drive imem_req_o=0 and inst_valid_o=0.
REQ-030 SHALL abandon any outstanding request on reset; a response arriving after reset is ignored (state IDLE).
REQ-031 SHALL assert the first imem_req_o, with imem_addr_o=RESET_PC, on the first cycle rst_ni=1.

Structure
REQ-032 SHALL place in the shared CPU package: the FSM state encoding (fetch_state_t: IDLE, WAIT, FLUSH), the PC increment constant 4, and the queue entry type {pc[31:0], inst[31:0]}.
REQ-033 SHALL implement the queue as sub-module inst_queue: synchronous FIFO with push, pop, flush, and count outputs.

Verification
REQ-034 Reset release, memory latency 1, inst_ready_i=1 -> requests at 0x0, 0x4, 0x8; inst_pc_o 0x0, 0x4, 0x8 with matching words.
REQ-035 inst_ready_i=0 for 20 cycles -> exactly QDEPTH=4 entries buffered, imem_req_o stays 0, head stable; release -> 4 pops in order.
REQ-036 redirect_i with redirect_pc_i=0x103 while in WAIT -> stale rvalid dropped, next request addr 0x100, queue empty.
REQ-037 redirect_i coinciding with imem_rvalid_i -> data not enqueued, next imem_addr_o = redirect target.
REQ-038 Redirect to 0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0000_0000.
REQ-039 rst_ni=0 during WAIT, late rvalid after release -> ignored; first fetch at RESET_PC.
